// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and default MISR constants for the BIST response analyser
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_POLY = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h00;

endpackage

// File: rtl/bist_misr_ora_misr_reg.sv
// rtl/bist_misr_ora_misr_reg.sv - multiple-input signature register; SIG_SCANOUT_EN adds a plain shift-out mode
module misr_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
`ifdef SIG_SCANOUT_EN
    input  logic             shift,
`endif
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (enable) begin
            q <= {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ data;
`ifdef SIG_SCANOUT_EN
        end else if (shift) begin
            // Unload path: plain shift with zero fill, no feedback taps.
            q <= {q[WIDTH-2:0], 1'b0};
`endif
        end
    end

endmodule

// File: rtl/bist_misr_ora.sv
// rtl/bist_misr_ora.sv - BIST output response analyser: run FSM, word counter, golden compare; SIG_SCANOUT_EN enables signature scan-out
module bist_misr_ora
    import bist_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               NUM_CYCLES = 1000,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] GOLDEN     = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic [WIDTH-1:0] resp_in,
    input  logic             resp_valid,
    output logic             busy,
    output logic [WIDTH-1:0] sig_out,
    output logic             bist_end,
    output logic             pass_fail
`ifdef SIG_SCANOUT_EN
    ,
    output logic             scan_out
`endif
);

    localparam int            CW   = $clog2(NUM_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_CYCLES - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             load, enable;
    logic [WIDTH-1:0] misr;
`ifdef SIG_SCANOUT_EN
    logic             shift;
`endif

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .CLK    (CLK),
        .RST    (RST),
        .load   (load),
        .seed   (SEED),
        .enable (enable),
        .data   (resp_in),
`ifdef SIG_SCANOUT_EN
        .shift  (shift),
`endif
        .q      (misr)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        enable  = 1'b0;
`ifdef SIG_SCANOUT_EN
        shift   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bist_start) begin
                    load    = 1'b1;
                    state_n = COMPACT;
                end
            end
            COMPACT: begin
                if (resp_valid) begin
                    enable = 1'b1;
                    if (cnt == LAST) state_n = COMPARE;
                end
            end
            COMPARE: state_n = DONE;
            DONE: begin
                // Holding bist_start keeps the result up until the controller releases it.
                if (!bist_start) state_n = IDLE;
`ifdef SIG_SCANOUT_EN
                else             shift   = 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
        end else begin
            state <= state_n;
            if (load)        cnt <= '0;
            else if (enable) cnt <= cnt + 1'b1;
            if (state == COMPARE) begin
                pass_fail <= (misr == GOLDEN);
                bist_end  <= 1'b1;
            end else if (state == DONE && !bist_start) begin
                pass_fail <= 1'b0;
                bist_end  <= 1'b0;
            end
        end
    end

    assign busy    = (state == COMPACT) || (state == COMPARE);
    assign sig_out = misr;
`ifdef SIG_SCANOUT_EN
    assign scan_out = misr[WIDTH-1];
`endif

endmodule

// File: tb/tb_bist_misr_ora.sv
// tb/tb_bist_misr_ora.sv - scoreboard bench for bist_misr_ora over three parameter sets; SIG_SCANOUT_EN adds scan-out checks
module tb_bist_misr_ora;

    localparam logic [7:0] POLY = 8'hB8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] rin;
    logic       rv;
    logic       start [3];
    logic       busy  [3];
    logic       bend  [3];
    logic       pf    [3];
    logic [7:0] sig   [3];
`ifdef SIG_SCANOUT_EN
    logic       scan  [3];
`endif

    always #5 CLK = ~CLK;

    bist_misr_ora u0 (
        .CLK(CLK), .RST(RST), .bist_start(start[0]), .resp_in(rin), .resp_valid(rv),
        .busy(busy[0]), .sig_out(sig[0]), .bist_end(bend[0]), .pass_fail(pf[0])
`ifdef SIG_SCANOUT_EN
        , .scan_out(scan[0])
`endif
    );

    bist_misr_ora #(.NUM_CYCLES(2)) u1 (
        .CLK(CLK), .RST(RST), .bist_start(start[1]), .resp_in(rin), .resp_valid(rv),
        .busy(busy[1]), .sig_out(sig[1]), .bist_end(bend[1]), .pass_fail(pf[1])
`ifdef SIG_SCANOUT_EN
        , .scan_out(scan[1])
`endif
    );

    bist_misr_ora #(.NUM_CYCLES(4), .SEED(8'h3C), .GOLDEN(8'h5A)) u2 (
        .CLK(CLK), .RST(RST), .bist_start(start[2]), .resp_in(rin), .resp_valid(rv),
        .busy(busy[2]), .sig_out(sig[2]), .bist_end(bend[2]), .pass_fail(pf[2])
`ifdef SIG_SCANOUT_EN
        , .scan_out(scan[2])
`endif
    );

    typedef struct {
        int         id;
        logic [7:0] sig;
        logic       pf;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] words [$];
    int         total = 0;
    int         bad   = 0;
    logic       bend_q [3];

    function automatic logic [7:0] seed_of(input int k);
        return (k == 2) ? 8'h3C : 8'h00;
    endfunction

    function automatic logic [7:0] gold_of(input int k);
        return (k == 2) ? 8'h5A : 8'h00;
    endfunction

    function automatic int ncyc_of(input int k);
        return (k == 0) ? 1000 : (k == 1) ? 2 : 4;
    endfunction

    // Reference signature update: multiply by x modulo 256, fold in taps on overflow, add the word.
    function automatic logic [7:0] step(input logic [7:0] m, input logic [7:0] d);
        int v;
        v = int'(m) * 2;
        if (v >= 256) v = (v - 256) ^ int'(POLY);
        return 8'(v) ^ d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (bend[k] === 1'b1 && bend_q[k] !== 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("end_id", k, e.id);
                    chk("end_sig", {24'd0, sig[k]}, {24'd0, e.sig});
                    chk("end_pass_fail", {31'd0, pf[k]}, {31'd0, e.pf});
                end
            end
            bend_q[k] = bend[k];
        end
    end

    task automatic fill_random(input int k, input bit force_pass);
        logic [7:0] m;
        words.delete();
        m = seed_of(k);
        for (int i = 0; i < ncyc_of(k); i++) begin
            words.push_back(8'($urandom));
            if (i < ncyc_of(k) - 1) m = step(m, words[i]);
        end
        if (force_pass) words[ncyc_of(k) - 1] = gold_of(k) ^ step(m, 8'h00);
    endtask

    // Called at a negedge with the target instance in IDLE.
    task automatic run(input int k, input bit gaps);
        logic [7:0] m;
        exp_t       e;
        m = seed_of(k);
        foreach (words[i]) m = step(m, words[i]);
        e.id  = k;
        e.sig = m;
        e.pf  = (m == gold_of(k));
        sb.push_back(e);

        start[k] = 1'b1;
        rv = 1'b0;
        @(negedge CLK);
        chk("start_busy", {31'd0, busy[k]}, 32'd1);
        chk("start_seed", {24'd0, sig[k]}, {24'd0, seed_of(k)});
        m = seed_of(k);
        foreach (words[i]) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                rv  = 1'b0;
                rin = 8'($urandom);
                @(negedge CLK);
                chk("gap_hold", {24'd0, sig[k]}, {24'd0, m});
            end
            rv  = 1'b1;
            rin = words[i];
            @(negedge CLK);
            m = step(m, words[i]);
            chk("word_sig", {24'd0, sig[k]}, {24'd0, m});
            chk("word_busy", {31'd0, busy[k]}, 32'd1);
        end
        rv = 1'b0;
        chk("end_early", {31'd0, bend[k]}, 32'd0);
        @(negedge CLK);
        chk("end_rise", {31'd0, bend[k]}, 32'd1);
        chk("done_busy", {31'd0, busy[k]}, 32'd0);
`ifdef SIG_SCANOUT_EN
        for (int j = 0; j < 8; j++) begin
            chk("scan_bit", {31'd0, scan[k]}, {31'd0, m[7-j]});
            chk("scan_pf", {31'd0, pf[k]}, {31'd0, e.pf});
            @(negedge CLK);
        end
`else
        @(negedge CLK);
        chk("done_sig_hold", {24'd0, sig[k]}, {24'd0, m});
        chk("done_pf_hold", {31'd0, pf[k]}, {31'd0, e.pf});
`endif
        start[k] = 1'b0;
        @(negedge CLK);
        chk("idle_end", {31'd0, bend[k]}, 32'd0);
        chk("idle_pf", {31'd0, pf[k]}, 32'd0);
        chk("idle_busy", {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k]  = 1'b0;
            bend_q[k] = 1'b0;
        end
        rin = 8'h00;
        rv  = 1'b0;
        RST = 1'b0;

        // Reset dominates whatever the inputs do.
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) start[k] = 1'($urandom);
            rin = 8'($urandom);
            rv  = 1'($urandom);
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                chk("rst_busy", {31'd0, busy[k]}, 32'd0);
                chk("rst_end", {31'd0, bend[k]}, 32'd0);
                chk("rst_pf", {31'd0, pf[k]}, 32'd0);
                chk("rst_sig", {24'd0, sig[k]}, 32'd0);
            end
        end
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        rv  = 1'b0;
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                chk("idle_stay_busy", {31'd0, busy[k]}, 32'd0);
                chk("idle_stay_sig", {24'd0, sig[k]}, 32'd0);
            end
        end

        // Full-length default run with all-zero responses.
        words.delete();
        for (int i = 0; i < 1000; i++) words.push_back(8'h00);
        run(0, 1'b0);

        // Two-word run: 80 then 00 lands on the tap pattern.
        words.delete();
        words.push_back(8'h80);
        words.push_back(8'h00);
        run(1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_random(1, r[0]);
            run(1, 1'b1);
        end
        for (int r = 0; r < 8; r++) begin
            fill_random(2, r[0]);
            run(2, 1'b1);
        end

        // Reset in the middle of a run, then a clean rerun.
        start[2] = 1'b1;
        @(negedge CLK);
        rv  = 1'b1;
        rin = 8'($urandom);
        @(negedge CLK);
        rin = 8'($urandom);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy[2]}, 32'd0);
        chk("midrst_end", {31'd0, bend[2]}, 32'd0);
        chk("midrst_pf", {31'd0, pf[2]}, 32'd0);
        chk("midrst_sig", {24'd0, sig[2]}, 32'd0);
        start[2] = 1'b0;
        rv = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        fill_random(2, 1'b1);
        run(2, 1'b0);

        @(negedge CLK);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
